// File: rtl/irq_ctl_pkg.sv
// Shared CSR constants, controller state type and mcause helpers for irq_ctl.
package irq_ctl_pkg;

   localparam int unsigned CSR__MCAUSE_INT_BIT = 31;
   localparam logic [31:0] CSR__NMI_CAUSE      = 32'h8000_0000;
   localparam int unsigned CSR__MI_LOCAL_BASE  = 16;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_ctl_state_t;

   function automatic logic [31:0] irq_cause(input int unsigned base, input logic [4:0] id);
      logic [31:0] cause;
      cause = base + 32'(id);
      cause[CSR__MCAUSE_INT_BIT] = 1'b1;
      return cause;
   endfunction

   function automatic logic [31:0] irq_vec_off(input logic [31:0] cause);
      return {cause[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Input synchroniser chain followed by a rising-edge detector on the synced level.
module irq_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);

   logic prev_q;

   if (STAGES == 0) begin : g_bypass
      assign level = din;
   end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
         if (rst) sync_q <= '0;
         else     sync_q <= (sync_q << 1) | STAGES'(din);
      end
      assign level = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level;
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/irq_ctl.sv
// Machine-mode interrupt controller: synchronised sources, pending capture, fixed priority
// selection and a request/in-service tracker with NMI pre-emption.
module irq_ctl
   import irq_ctl_pkg::*;
#(
   parameter int unsigned        NUM_IRQ     = 16,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter int unsigned        CAUSE_BASE  = CSR__MI_LOCAL_BASE,
   parameter logic [31:0]        NMI_CAUSE   = CSR__NMI_CAUSE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               nmi,
   input  logic               mie_global,
   input  logic [NUM_IRQ-1:0] irq_enable,
   input  logic               boundary,
   input  logic               conflict,
   input  logic               take,
   input  logic               mret,
   output logic               int_req,
   output logic               int_nmi,
   output logic [4:0]         int_id,
   output logic [31:0]        int_cause,
   output logic [31:0]        vec_off,
   output logic [NUM_IRQ-1:0] pending
);

   logic [NUM_IRQ:0]   raw_all, level_all, rise_all;
   logic [NUM_IRQ-1:0] level, rise, pending_q, pending_d, edge_clr;
   logic [NUM_IRQ-1:0] elig, sel_oh, oh_q, lat_oh;
   logic               nmi_rise, nmi_pend_q, nmi_clr, nmi_active_q;
   logic               take_ok, withdraw, unused_nmi_level;
   logic [4:0]         sel_id, lat_id;
   logic [31:0]        lat_cause;
   irq_ctl_state_t     state_q;

   // Bit NUM_IRQ of the combined vector carries NMI through the same sync/edge path.
   assign raw_all = {nmi, irq};

   for (genvar g = 0; g <= NUM_IRQ; g++) begin : g_src
      irq_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst   (rst),
         .din   (raw_all[g]),
         .level (level_all[g]),
         .rise  (rise_all[g])
      );
   end

   assign level            = level_all[NUM_IRQ-1:0];
   assign rise             = rise_all[NUM_IRQ-1:0];
   assign nmi_rise         = rise_all[NUM_IRQ];
   assign unused_nmi_level = level_all[NUM_IRQ];

   assign take_ok  = (state_q == REQ) && int_req && take;
   assign edge_clr = (take_ok && !int_nmi) ? (oh_q & EDGE_MASK) : '0;
   assign nmi_clr  = take_ok && int_nmi;

   // Edge sources hold until taken; a same-cycle new edge wins over the clear.
   assign pending_d = (EDGE_MASK & (rise | (pending_q & ~edge_clr))) | (~EDGE_MASK & level);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         nmi_pend_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         nmi_pend_q <= nmi_rise | (nmi_pend_q & ~nmi_clr);
      end
   end

   assign pending = pending_q;
   assign elig    = pending_q & irq_enable & {NUM_IRQ{mie_global & ~nmi_active_q}};
   assign sel_oh  = elig & (~elig + NUM_IRQ'(1));

   always_comb begin
      sel_id = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) sel_id = 5'(i);
      end
   end

   assign lat_id    = nmi_pend_q ? 5'd0 : sel_id;
   assign lat_oh    = nmi_pend_q ? '0 : sel_oh;
   assign lat_cause = nmi_pend_q ? NMI_CAUSE : irq_cause(CAUSE_BASE, sel_id);
   assign withdraw  = !mie_global || !(|(oh_q & pending_q & irq_enable));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         int_req      <= 1'b0;
         int_nmi      <= 1'b0;
         int_id       <= '0;
         oh_q         <= '0;
         int_cause    <= '0;
         vec_off      <= '0;
         nmi_active_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (boundary && !conflict && (nmi_pend_q || (|elig))) begin
                  state_q   <= REQ;
                  int_nmi   <= nmi_pend_q;
                  int_id    <= lat_id;
                  oh_q      <= lat_oh;
                  int_cause <= lat_cause;
                  vec_off   <= irq_vec_off(lat_cause);
               end
            end
            REQ: begin
               if (take_ok) begin
                  state_q <= SERVICE;
                  int_req <= 1'b0;
                  if (int_nmi) nmi_active_q <= 1'b1;
               end else if (!int_nmi && nmi_pend_q) begin
                  int_nmi   <= 1'b1;
                  int_id    <= lat_id;
                  oh_q      <= lat_oh;
                  int_cause <= lat_cause;
                  vec_off   <= irq_vec_off(lat_cause);
                  int_req   <= 1'b1;
               end else if (!int_nmi && withdraw) begin
                  state_q   <= IDLE;
                  int_req   <= 1'b0;
                  int_nmi   <= 1'b0;
                  int_id    <= '0;
                  oh_q      <= '0;
                  int_cause <= '0;
                  vec_off   <= '0;
               end else begin
                  int_req <= 1'b1;
               end
            end
            SERVICE: begin
               if (mret) begin
                  state_q      <= IDLE;
                  nmi_active_q <= 1'b0;
               end else if (!nmi_active_q && nmi_pend_q && boundary && !conflict) begin
                  state_q   <= REQ;
                  int_nmi   <= 1'b1;
                  int_id    <= lat_id;
                  oh_q      <= lat_oh;
                  int_cause <= lat_cause;
                  vec_off   <= irq_vec_off(lat_cause);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
